// File: rtl/mips8_pkg.sv
// mips8_pkg: shared constants for the 8-bit MIPS fetch path.
//   PC_W          program-counter / imem address width
//   INSTR_W_DEF   default instruction word width
//   RESET_PC_DEF  default PC after reset
//   PC_INC_DEF    default sequential increment (word-addressed imem)
//   ST_*          fetch controller state encoding
package mips8_pkg;

  localparam int PC_W        = 8;
  localparam int INSTR_W_DEF = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;
  localparam logic [PC_W-1:0] PC_INC_DEF   = 8'd1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory and decode handshake bundle.
//   imem_req/imem_addr -> imem, imem_ack/imem_data <- imem
//   ir/ir_valid -> decode, ir_ready/br_taken/br_off/jmp/jmp_addr <- decode
// master = fetch controller side, slave = imem/decode side.
interface pc_fetch_ctrl_if
  import mips8_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               ir_ready;
  logic               br_taken;
  logic [PC_W-1:0]    br_off;
  logic               jmp;
  logic [PC_W-1:0]    jmp_addr;

  modport master (
    output imem_req, imem_addr, ir, ir_valid,
    input  imem_ack, imem_data, ir_ready, br_taken, br_off, jmp, jmp_addr
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid,
    output imem_ack, imem_data, ir_ready, br_taken, br_off, jmp, jmp_addr
  );

endinterface

// File: rtl/pc_fetch_fsm.sv
// pc_fetch_fsm: fetch controller state register and handshake decode.
//   clk, rst_n      clock, async active-low reset
//   start_i         IDLE -> FETCH
//   imem_ack_i      imem data valid (used in FETCH only)
//   ir_ready_i      decode accepts IR (used in HOLD only)
//   halt_req_i      go to HALT after this accept
//   wrap_trap_i     sequential accept would wrap PC (trap build only)
//   fetch_o/hold_o/halt_o   state decodes (from the state flop)
//   capture_o       load IR this cycle
//   accept_o        IR consumed this cycle, PC may update
module pc_fetch_fsm
  import mips8_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic imem_ack_i,
  input  logic ir_ready_i,
  input  logic halt_req_i,
  input  logic wrap_trap_i,
  output logic fetch_o,
  output logic hold_o,
  output logic halt_o,
  output logic capture_o,
  output logic accept_o
);

  logic [1:0] state_q, state_d;

  // Next-state logic; HALT is sticky until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
        else         state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack_i) state_d = ST_HOLD;
        else            state_d = ST_FETCH;
      end
      ST_HOLD: begin
        if (ir_ready_i) begin
          if (halt_req_i || wrap_trap_i) state_d = ST_HALT;
          else                           state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign fetch_o   = (state_q == ST_FETCH);
  assign hold_o    = (state_q == ST_HOLD);
  assign halt_o    = (state_q == ST_HALT);
  assign capture_o = fetch_o & imem_ack_i;
  assign accept_o  = hold_o & ir_ready_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction fetch controller.
//   clk, rst_n        clock, async active-low reset
//   start_i           begin fetching (IDLE only)
//   halt_req_i        halt after the current instruction is accepted
//   bus (master)      imem req/ack fetch port and decode valid/ready port
//   add_a_o/add_b_o   external adder operands (PC, increment or branch offset)
//   add_sum_i/add_co_i external adder result / carry-out
//   pc_o, halted_o, trap_o  status
// Build option: PC_WRAP_TRAP_EN -- a sequential PC wrap from 8'hFF halts with
// TRAP=1 and PC held; without it the PC wraps silently and TRAP is 0.
module pc_fetch_ctrl
  import mips8_pkg::*;
#(
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] PC_INC   = PC_INC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  halt_req_i,
  pc_fetch_ctrl_if.master       bus,
  output logic [PC_W-1:0]       add_a_o,
  output logic [PC_W-1:0]       add_b_o,
  input  logic [PC_W-1:0]       add_sum_i,
  input  logic                  add_co_i,
  output logic [PC_W-1:0]       pc_o,
  output logic                  halted_o,
  output logic                  trap_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic fetch_s, hold_s, halt_s, capture_s, accept_s, wrap_trap_s;

  pc_fetch_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .imem_ack_i  (bus.imem_ack),
    .ir_ready_i  (bus.ir_ready),
    .halt_req_i  (halt_req_i),
    .wrap_trap_i (wrap_trap_s),
    .fetch_o     (fetch_s),
    .hold_o      (hold_s),
    .halt_o      (halt_s),
    .capture_o   (capture_s),
    .accept_o    (accept_s)
  );

`ifdef PC_WRAP_TRAP_EN
  logic seq_s;
  logic trap_q, trap_d;

  // Carry-out only matters for the plain increment; branch offsets wrap by design.
  assign seq_s       = ~bus.jmp & ~bus.br_taken;
  assign wrap_trap_s = accept_s & seq_s & add_co_i;

  // Trap flag is sticky until reset.
  always_comb begin
    if (wrap_trap_s) trap_d = 1'b1;
    else             trap_d = trap_q;
  end

  // Trap register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign trap_o = trap_q;
`else
  logic add_co_unused_s;

  assign add_co_unused_s = add_co_i;
  assign wrap_trap_s     = 1'b0;
  assign trap_o          = 1'b0;
`endif

  // Next PC: moves only on accept; a trapping wrap leaves it untouched.
  always_comb begin
    pc_d = pc_q;
    if (accept_s && !wrap_trap_s) begin
      if (bus.jmp) pc_d = bus.jmp_addr;
      else         pc_d = add_sum_i;
    end else begin
      pc_d = pc_q;
    end
  end

  // IR loads on the imem ack while fetching, otherwise holds.
  always_comb begin
    ir_d = ir_q;
    if (capture_s) ir_d = bus.imem_data;
    else           ir_d = ir_q;
  end

  // PC and IR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      ir_q <= {INSTR_W{1'b0}};
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign add_a_o       = pc_q;
  assign add_b_o       = bus.br_taken ? bus.br_off : PC_INC;
  assign bus.imem_req  = fetch_s;
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = hold_s;
  assign pc_o          = pc_q;
  assign halted_o      = halt_s;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table vectors, directed corner sequences and a randomized
// run against an abstract fetch model for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
  import mips8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt_req;
  logic [7:0] add_a, add_b, add_sum, pc;
  logic       add_co, halted, trap;
  int         vec_cnt  = 0;
  int         miss_cnt = 0;

  pc_fetch_ctrl_if #(.INSTR_W(32)) bus ();

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .halt_req_i(halt_req), .bus(bus),
    .add_a_o(add_a), .add_b_o(add_b), .add_sum_i(add_sum), .add_co_i(add_co),
    .pc_o(pc), .halted_o(halted), .trap_o(trap)
  );

  // External 8-bit adder of the core.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  typedef struct {
    logic        start, ack, ready;
    logic [31:0] data;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ir;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic req, input logic [7:0] addr,
                            input logic val, input logic [31:0] ir,
                            input logic hlt, input logic trp);
    chk({nm, ".imem_req"},  {31'd0, bus.imem_req}, {31'd0, req});
    chk({nm, ".imem_addr"}, {24'd0, bus.imem_addr}, {24'd0, addr});
    chk({nm, ".pc"},        {24'd0, pc}, {24'd0, addr});
    chk({nm, ".ir_valid"},  {31'd0, bus.ir_valid}, {31'd0, val});
    chk({nm, ".ir"},        bus.ir, ir);
    chk({nm, ".halted"},    {31'd0, halted}, {31'd0, hlt});
    chk({nm, ".trap"},      {31'd0, trap}, {31'd0, trp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 1'b0; halt_req = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'd0; bus.ir_ready = 1'b0;
    bus.br_taken = 1'b0; bus.br_off = 8'd0; bus.jmp = 1'b0; bus.jmp_addr = 8'd0;
  endtask

  // One-cycle imem ack delivering d.
  task automatic fetch(input logic [31:0] d);
    bus.imem_ack = 1'b1; bus.imem_data = d;
    step();
    bus.imem_ack = 1'b0;
  endtask

  // One-cycle decode accept with the given control-flow inputs.
  task automatic accept(input logic br, input logic [7:0] off, input logic j,
                        input logic [7:0] ja, input logic hr);
    bus.br_taken = br; bus.br_off = off; bus.jmp = j; bus.jmp_addr = ja;
    halt_req = hr; bus.ir_ready = 1'b1;
    step();
    clear_in();
  endtask

  // Async reset pulse, released on a falling edge, then START.
  task automatic reset_and_start();
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    logic        m_has, m_halt, m_trap;
    logic [7:0]  m_pc;
    logic [31:0] m_ir;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 8'h00, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 8'h00, 1'b1, 32'h11};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h22, 1'b1, 8'h01, 1'b0, 32'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 8'h01, 1'b1, 32'h33};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 8'h02, 1'b0, 32'h33};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 8'h02, 1'b1, 32'h55};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h66, 1'b1, 8'h03, 1'b0, 32'h55};

    rst_n = 1'b0;
    clear_in();
    #12;
    expect_out("reset", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Zero-wait imem, always-ready decode: one instruction every two cycles.
    for (int i = 0; i < 7; i++) begin
      start = tbl[i].start; bus.imem_ack = tbl[i].ack;
      bus.ir_ready = tbl[i].ready; bus.imem_data = tbl[i].data;
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                 tbl[i].exp_valid, tbl[i].exp_ir, 1'b0, 1'b0);
    end
    clear_in();

    // Jump to 10, branch -4 to 0C, jump wins over branch to 40.
    fetch(32'hB0);
    expect_out("t2.hold", 1'b0, 8'h03, 1'b1, 32'hB0, 1'b0, 1'b0);
    accept(1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
    expect_out("t2.jmp10", 1'b1, 8'h10, 1'b0, 32'hB0, 1'b0, 1'b0);
    fetch(32'hB1);
    bus.br_taken = 1'b1; bus.br_off = 8'hFC;
    #1;
    chk("t2.add_a", {24'd0, add_a}, 32'h10);
    chk("t2.add_b", {24'd0, add_b}, 32'hFC);
    accept(1'b1, 8'hFC, 1'b0, 8'h00, 1'b0);
    expect_out("t2.br", 1'b1, 8'h0C, 1'b0, 32'hB1, 1'b0, 1'b0);
    fetch(32'hB2);
    accept(1'b1, 8'h04, 1'b1, 8'h40, 1'b0);
    expect_out("t2.jmpbr", 1'b1, 8'h40, 1'b0, 32'hB2, 1'b0, 1'b0);

    // Slow imem (3 cycles) and stalled decode (4 cycles).
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("t3.wait%0d", i), 1'b1, 8'h40, 1'b0, 32'hB2, 1'b0, 1'b0);
    end
    fetch(32'hC3);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("t3.stall%0d", i), 1'b0, 8'h40, 1'b1, 32'hC3, 1'b0, 1'b0);
    end
    accept(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    expect_out("t3.seq", 1'b1, 8'h41, 1'b0, 32'hC3, 1'b0, 1'b0);

    // Sequential accept at PC=FF.
    fetch(32'hD0);
    accept(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    fetch(32'hD1);
    expect_out("t4.hold", 1'b0, 8'hFF, 1'b1, 32'hD1, 1'b0, 1'b0);
    chk("t4.add_b", {24'd0, add_b}, 32'h01);
    accept(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef PC_WRAP_TRAP_EN
    expect_out("t4.trap", 1'b0, 8'hFF, 1'b0, 32'hD1, 1'b1, 1'b1);
`else
    expect_out("t4.wrap", 1'b1, 8'h00, 1'b0, 32'hD1, 1'b0, 1'b0);
`endif

    // HALT_REQ on accept; START/ACK ignored afterwards until reset.
    reset_and_start();
    expect_out("t5.start", 1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'hE0);
    accept(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    expect_out("t5.halt", 1'b0, 8'h01, 1'b0, 32'hE0, 1'b1, 1'b0);
    start = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 32'hEE; bus.ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("t5.stay%0d", i), 1'b0, 8'h01, 1'b0, 32'hE0, 1'b1, 1'b0);
    end
    clear_in();

    // Async reset mid-FETCH (with an ack in flight) and mid-HOLD.
    reset_and_start();
    bus.imem_ack = 1'b1; bus.imem_data = 32'hF0;
    #3 rst_n = 1'b0;
    #1 expect_out("t6.rst_fetch", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    expect_out("t6.rst_held", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_in();
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    fetch(32'hF1);
    expect_out("t6.hold", 1'b0, 8'h00, 1'b1, 32'hF1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 expect_out("t6.rst_hold", 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);

    // Randomized run against an abstract model: instruction pending or not.
    @(negedge clk) rst_n = 1'b1;
    start = 1'b1;
    step();
    m_has = 1'b0; m_halt = 1'b0; m_trap = 1'b0; m_pc = 8'h00; m_ir = 32'h0;
    for (int i = 0; i < 400; i++) begin
      start        = 1'($urandom_range(0, 1));
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.imem_data = $urandom;
      bus.ir_ready = 1'($urandom_range(0, 1));
      bus.br_taken = ($urandom_range(0, 3) == 0);
      bus.br_off   = 8'($urandom);
      bus.jmp      = ($urandom_range(0, 7) == 0);
      bus.jmp_addr = (i % 50 == 0) ? 8'hFF : 8'($urandom);
      if (!m_halt) begin
        if (!m_has) begin
          if (bus.imem_ack) begin
            m_ir  = bus.imem_data;
            m_has = 1'b1;
          end
        end else if (bus.ir_ready) begin
          m_has = 1'b0;
          if (bus.jmp)           m_pc = bus.jmp_addr;
          else if (bus.br_taken) m_pc = 8'((int'(m_pc) + int'(bus.br_off)) % 256);
`ifdef PC_WRAP_TRAP_EN
          else if (m_pc == 8'hFF) begin
            m_halt = 1'b1;
            m_trap = 1'b1;
          end
`endif
          else m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
      step();
      expect_out($sformatf("rand%0d", i), !m_has && !m_halt, m_pc, m_has,
                 m_ir, m_halt, m_trap);
    end
    clear_in();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
